// File: rtl/rv3n_bpred_bht_pkg.sv
// Shared constants for the rv3n branch history table: data-path width and
// the 2-bit saturating counter encoding.
package rv3n_bpred_bht_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] BHT_SNT  = 2'd0;
    localparam logic [1:0] BHT_WNT  = 2'd1;
    localparam logic [1:0] BHT_WT   = 2'd2;
    localparam logic [1:0] BHT_ST   = 2'd3;
    localparam logic [1:0] BHT_INIT = BHT_WNT;

    // The predicted direction is the counter MSB (weak-T and strong-T are taken).
    function automatic logic bht_predict(input logic [1:0] cnt);
        return cnt[1];
    endfunction

endpackage

// File: rtl/rv3n_bpred_bht_sat2.sv
// rv3n_sat2: combinational next state of a 2-bit saturating direction counter.
// Used for both the table write and the same-cycle forwarding value.
module rv3n_sat2
    import rv3n_bpred_bht_pkg::*;
(
    input  logic [1:0] i_cnt,
    input  logic       i_taken,
    output logic [1:0] o_cnt
);

    // Increment toward strong-T on taken, decrement toward strong-NT otherwise.
    always_comb begin
        o_cnt = i_cnt;
        if (i_taken) begin
            if (i_cnt == BHT_ST) begin
                o_cnt = BHT_ST;
            end else begin
                o_cnt = i_cnt + 2'd1;
            end
        end else begin
            if (i_cnt == BHT_SNT) begin
                o_cnt = BHT_SNT;
            end else begin
                o_cnt = i_cnt - 2'd1;
            end
        end
    end

endmodule

// File: rtl/rv3n_bpred_bht.sv
// rv3n_bpred_bht: bimodal branch history table with registered prediction and
// perf counters. Defining RV3N_BHT_GSHARE_EN XORs a global history into the index.
module rv3n_bpred_bht
    import rv3n_bpred_bht_pkg::*;
#(
    parameter int IDX_W = 6,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ch2predictor_valid,
    input  logic [XLEN-1:0]  ch2predictor_pc,
    input  logic             ch2predictor_predict,
    input  logic             ch2predictor_taken,
    input  logic             fetch_query_valid,
    input  logic [XLEN-1:0]  fetch_query_pc,
    output logic             bht_pred_valid,
    output logic             bht_pred_taken,
    output logic [CNT_W-1:0] perf_branch_cnt,
    output logic [CNT_W-1:0] perf_miss_cnt
);

    localparam int DEPTH = 1 << IDX_W;

    logic [1:0]       r_table [DEPTH];
    logic [IDX_W-1:0] w_upd_idx;
    logic [IDX_W-1:0] w_qry_idx;
    logic [1:0]       w_upd_cur;
    logic [1:0]       w_upd_next;
    logic [1:0]       w_qry_cnt;
    logic             r_pred_valid;
    logic             r_pred_taken;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_miss_cnt;
    logic             w_unused_pc;

    assign w_unused_pc = ^{ch2predictor_pc[XLEN-1:IDX_W+2], ch2predictor_pc[1:0],
                           fetch_query_pc[XLEN-1:IDX_W+2], fetch_query_pc[1:0]};

`ifdef RV3N_BHT_GSHARE_EN
    logic [IDX_W-1:0] r_ghr;

    // Global history: each resolved branch shifts its outcome into the LSB.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ghr <= {IDX_W{1'b0}};
        end else if (ch2predictor_valid) begin
            r_ghr <= {r_ghr[IDX_W-2:0], ch2predictor_taken};
        end
    end

    // Both indices use the history as it stood before this cycle's shift.
    assign w_upd_idx = ch2predictor_pc[IDX_W+1:2] ^ r_ghr;
    assign w_qry_idx = fetch_query_pc[IDX_W+1:2] ^ r_ghr;
`else
    assign w_upd_idx = ch2predictor_pc[IDX_W+1:2];
    assign w_qry_idx = fetch_query_pc[IDX_W+1:2];
`endif

    assign w_upd_cur = r_table[w_upd_idx];

    rv3n_sat2 u_sat2 (
        .i_cnt   (w_upd_cur),
        .i_taken (ch2predictor_taken),
        .o_cnt   (w_upd_next)
    );

    // A query that hits the entry being trained this cycle sees the trained value.
    always_comb begin
        w_qry_cnt = r_table[w_qry_idx];
        if (ch2predictor_valid && (w_upd_idx == w_qry_idx)) begin
            w_qry_cnt = w_upd_next;
        end else begin
            w_qry_cnt = r_table[w_qry_idx];
        end
    end

    // Counter table; a flop array so the asynchronous reset reaches every entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_table[i] <= BHT_INIT;
            end
        end else if (ch2predictor_valid) begin
            r_table[w_upd_idx] <= w_upd_next;
        end
    end

    // Registered prediction; the direction holds when no query is made.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pred_valid <= 1'b0;
            r_pred_taken <= 1'b0;
        end else begin
            r_pred_valid <= fetch_query_valid;
            if (fetch_query_valid) begin
                r_pred_taken <= bht_predict(w_qry_cnt);
            end
        end
    end

    // Perf counters wrap naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_branch_cnt <= {CNT_W{1'b0}};
            r_miss_cnt   <= {CNT_W{1'b0}};
        end else if (ch2predictor_valid) begin
            r_branch_cnt <= r_branch_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if (ch2predictor_predict != ch2predictor_taken) begin
                r_miss_cnt <= r_miss_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign bht_pred_valid  = r_pred_valid;
    assign bht_pred_taken  = r_pred_taken;
    assign perf_branch_cnt = r_branch_cnt;
    assign perf_miss_cnt   = r_miss_cnt;

endmodule

// File: tb/tb_rv3n_bpred_bht.sv
// Self-checking bench for rv3n_bpred_bht: directed scenarios followed by random
// traffic, all checked against a table-of-integers reference model.
module tb_rv3n_bpred_bht;

    localparam int IDX_W = 6;
    localparam int CNT_W = 16;
    localparam int XLEN  = rv3n_bpred_bht_pkg::XLEN;
    localparam int NENT  = 1 << IDX_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             ch2predictor_valid;
    logic [XLEN-1:0]  ch2predictor_pc;
    logic             ch2predictor_predict;
    logic             ch2predictor_taken;
    logic             fetch_query_valid;
    logic [XLEN-1:0]  fetch_query_pc;
    logic             bht_pred_valid;
    logic             bht_pred_taken;
    logic [CNT_W-1:0] perf_branch_cnt;
    logic [CNT_W-1:0] perf_miss_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model: plain integer counters 0..3 per entry.
    int model [NENT];
    int ghr;
    int br_cnt;
    int miss_cnt;
    bit exp_taken;

    always #5 clk = ~clk;

    rv3n_bpred_bht #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .ch2predictor_valid   (ch2predictor_valid),
        .ch2predictor_pc      (ch2predictor_pc),
        .ch2predictor_predict (ch2predictor_predict),
        .ch2predictor_taken   (ch2predictor_taken),
        .fetch_query_valid    (fetch_query_valid),
        .fetch_query_pc       (fetch_query_pc),
        .bht_pred_valid       (bht_pred_valid),
        .bht_pred_taken       (bht_pred_taken),
        .perf_branch_cnt      (perf_branch_cnt),
        .perf_miss_cnt        (perf_miss_cnt)
    );

    function automatic int idx_of(input logic [XLEN-1:0] pc);
        return (int'(pc >> 2) ^ ghr) % NENT;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: apply an optional update and query, advance the model, check outputs.
    task automatic cycle(input bit uv, input logic [XLEN-1:0] upc, input bit up, input bit ut,
                         input bit qv, input logic [XLEN-1:0] qpc);
        int ui;
        int qi;
        ch2predictor_valid   = uv;
        ch2predictor_pc      = upc;
        ch2predictor_predict = up;
        ch2predictor_taken   = ut;
        fetch_query_valid    = qv;
        fetch_query_pc       = qpc;
        qi = idx_of(qpc);
        if (uv) begin
            ui = idx_of(upc);
            if (ut) model[ui] = (model[ui] >= 3) ? 3 : model[ui] + 1;
            else    model[ui] = (model[ui] <= 0) ? 0 : model[ui] - 1;
            br_cnt++;
            if (up != ut) miss_cnt++;
`ifdef RV3N_BHT_GSHARE_EN
            ghr = ((ghr << 1) | int'(ut)) % NENT;
`endif
        end
        if (qv) exp_taken = (model[qi] >= 2);
        @(posedge clk);
        #1;
        check("pred_valid", 32'(bht_pred_valid), 32'(qv));
        check("pred_taken", 32'(bht_pred_taken), 32'(exp_taken));
        check("branch_cnt", 32'(perf_branch_cnt), 32'(br_cnt % (1 << CNT_W)));
        check("miss_cnt", 32'(perf_miss_cnt), 32'(miss_cnt % (1 << CNT_W)));
        ch2predictor_valid = 1'b0;
        fetch_query_valid  = 1'b0;
    endtask

    task automatic upd(input logic [XLEN-1:0] pc, input bit taken);
        cycle(1'b1, pc, 1'b0, taken, 1'b0, 32'h0);
    endtask

    // Query with an additional hand-derived expectation for the bimodal build.
    task automatic query_check(input string tag, input logic [XLEN-1:0] pc, input bit exp);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, pc);
`ifndef RV3N_BHT_GSHARE_EN
        check(tag, 32'(bht_pred_taken), 32'(exp));
`endif
    endtask

    initial begin
        logic [XLEN-1:0] pool [8];
        int b0;
        int m0;
        pool = '{32'h100, 32'h104, 32'h204, 32'h200, 32'h300, 32'h1300, 32'h0, 32'hC};

        rst                  = 1'b0;
        ch2predictor_valid   = 1'b0;
        ch2predictor_pc      = '0;
        ch2predictor_predict = 1'b0;
        ch2predictor_taken   = 1'b0;
        fetch_query_valid    = 1'b1;
        fetch_query_pc       = 32'h100;
        for (int i = 0; i < NENT; i++) model[i] = 1;
        ghr = 0; br_cnt = 0; miss_cnt = 0; exp_taken = 1'b0;

        // Reset held with a query pending: everything stays cleared.
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(bht_pred_valid), 32'h0);
        check("rst_taken", 32'(bht_pred_taken), 32'h0);
        check("rst_branch", 32'(perf_branch_cnt), 32'h0);
        check("rst_miss", 32'(perf_miss_cnt), 32'h0);
        fetch_query_valid = 1'b0;
        rst = 1'b1;
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

        query_check("reset_query", 32'h100, 1'b0);

        upd(32'h100, 1'b1);
        query_check("train_wt", 32'h100, 1'b1);
        repeat (3) upd(32'h100, 1'b1);
        upd(32'h100, 1'b0);
        query_check("train_back_to_2", 32'h100, 1'b1);

        repeat (5) upd(32'h200, 1'b0);
        upd(32'h200, 1'b1);
        query_check("sat_snt", 32'h200, 1'b0);

        cycle(1'b1, 32'h300, 1'b0, 1'b1, 1'b1, 32'h300);
`ifndef RV3N_BHT_GSHARE_EN
        check("forward", 32'(bht_pred_taken), 32'h1);
`endif

        upd(32'h104, 1'b1);
        query_check("alias", 32'h204, 1'b1);

        // Back-to-back queries return back-to-back results.
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h200);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h100);

        b0 = br_cnt;
        m0 = miss_cnt;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 32'h400, (i % 3 == 0) && (i < 9), 1'b0, 1'b0, 32'h0);
        end
        check("perf10_branch", 32'(perf_branch_cnt), 32'(b0 + 10));
        check("perf10_miss", 32'(perf_miss_cnt), 32'(m0 + 3));

        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)),
                  pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
